// File: rtl/tm1638_frame_scheduler_if.sv
// Byte-level link between the TM1638 frame scheduler
// and the SIO shifter that clocks bytes onto the pins.
interface tm1638_frame_scheduler_if;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       byte_read;
  logic       byte_last;
  logic       rd_valid;
  logic [7:0] rd_data;

  modport master (
    output byte_valid, byte_data, byte_read, byte_last,
    input  byte_ready, rd_valid, rd_data
  );

  modport slave (
    input  byte_valid, byte_data, byte_read, byte_last,
    output byte_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/tm1638_frame_scheduler.sv
// TM1638 refresh sequencer: mode, display write, control,
// then a 4-byte key scan, repeated at a fixed tick rate.
module tm1638_frame_scheduler #(
  parameter int clk_mhz        = 27,
  parameter int w_digit        = 8,
  parameter int refresh_cycles = 27000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [w_digit*8-1:0] segs,
  input  logic [7:0]           leds,
  input  logic [2:0]           brightness,
  input  logic                 display_on,
  tm1638_frame_scheduler_if.master bus,
  output logic [7:0]           keys,
  output logic                 keys_valid,
  output logic                 busy
);

  if (refresh_cycles < 64 || clk_mhz < 1 ||
      w_digit < 1 || w_digit > 8) begin : g_bad_param
    $error("tm1638_frame_scheduler: bad parameters");
  end

  localparam int cw = $clog2(refresh_cycles);

  typedef enum logic [3:0] {
    IDLE, MODE, ADDR, DATA, DISP,
    KCMD, KRD, KWAIT, DONE
  } state_t;

  state_t     state, state_n;
  logic [cw-1:0] cnt;
  logic       tick;
  logic       pend;
  logic       go;
  logic [3:0] idx;
  logic [63:0] seg_q;
  logic [7:0] leds_q;
  logic [2:0] br_q;
  logic       on_q;
  logic [2:0] rd_lo;
  logic [2:0] rd_hi;
  logic       bv;
  logic [7:0] bd;
  logic       brd;
  logic       bl;
  logic       xfer;

  assign tick = (cnt == cw'(refresh_cycles - 1));
  assign go   = tick | pend;
  assign xfer = bv & bus.byte_ready;

  // tick timer, pending flag, snapshot, byte index, key capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      pend   <= 1'b0;
      state  <= IDLE;
      idx    <= '0;
      seg_q  <= '0;
      leds_q <= '0;
      br_q   <= '0;
      on_q   <= 1'b0;
      rd_lo  <= '0;
      rd_hi  <= '0;
      keys   <= '0;
    end else begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      state <= state_n;
      if (state == IDLE)
        pend <= 1'b0;
      else if (tick)
        pend <= 1'b1;
      if (state == IDLE && go) begin
        seg_q  <= 64'(segs);
        leds_q <= leds;
        br_q   <= brightness;
        on_q   <= display_on;
      end
      if (state == ADDR || state == KCMD)
        idx <= '0;
      else if (state == DATA && xfer)
        idx <= idx + 1'b1;
      else if (state == KWAIT && bus.rd_valid)
        idx <= idx + 1'b1;
      if (state == KWAIT && bus.rd_valid) begin
        rd_lo <= {bus.rd_data[0], rd_lo[2:1]};
        rd_hi <= {bus.rd_data[4], rd_hi[2:1]};
        if (idx[1:0] == 2'd3)
          keys <= {bus.rd_data[4], rd_hi,
                   bus.rd_data[0], rd_lo};
      end
    end
  end

  // next state and the byte presented in each state
  always_comb begin
    state_n = state;
    bv      = 1'b0;
    bd      = 8'h00;
    brd     = 1'b0;
    bl      = 1'b0;
    unique case (state)
      IDLE: if (go) state_n = MODE;
      MODE: begin
        bv = 1'b1;
        bd = 8'h40;
        bl = 1'b1;
        if (bus.byte_ready) state_n = ADDR;
      end
      ADDR: begin
        bv = 1'b1;
        bd = 8'hC0;
        if (bus.byte_ready) state_n = DATA;
      end
      DATA: begin
        bv = 1'b1;
        bd = idx[0] ? {7'b0, leds_q[idx[3:1]]}
                    : seg_q[{idx[3:1], 3'b000} +: 8];
        bl = (idx == 4'd15);
        if (bus.byte_ready && idx == 4'd15)
          state_n = DISP;
      end
      DISP: begin
        bv = 1'b1;
        bd = on_q ? {5'b10001, br_q} : 8'h80;
        bl = 1'b1;
        if (bus.byte_ready) state_n = KCMD;
      end
      KCMD: begin
        bv = 1'b1;
        bd = 8'h42;
        if (bus.byte_ready) state_n = KRD;
      end
      KRD: begin
        bv  = 1'b1;
        brd = 1'b1;
        bl  = (idx[1:0] == 2'd3);
        if (bus.byte_ready) state_n = KWAIT;
      end
      KWAIT: begin
        if (bus.rd_valid)
          state_n = (idx[1:0] == 2'd3) ? DONE : KRD;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.byte_valid = bv;
  assign bus.byte_data  = bd;
  assign bus.byte_read  = brd;
  assign bus.byte_last  = bl;
  assign keys_valid     = (state == DONE);
  assign busy           = (state != IDLE);

endmodule
